// File: rtl/lsu_wb_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU state encoding, store lane bundle.
package lsu_wb_pkg;
   localparam int XLEN   = 32;
   localparam int NBYTES = XLEN / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_WB   = 2'd3
   } lsu_state_e;

   // Loads and stores share the access-size field in funct3[1:0]; bit 2 marks unsigned loads.
   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } mem_funct3_e;

   typedef struct packed {
      logic [NBYTES-1:0] be;
      logic [XLEN-1:0]   wdata;
   } store_lanes_t;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         default: return off != 2'b00;
      endcase
   endfunction
endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: load extract with sign/zero extension, store lane replication and byte enables.
// Purely combinational, no handshake; also used by the fetch side.
module lsu_align
   import lsu_wb_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      off_i,
   input  logic [XLEN-1:0] rdata_i,
   input  logic [XLEN-1:0] sdata_i,
   output logic [XLEN-1:0] ldata_o,
   output store_lanes_t    lanes_o
);
   mem_funct3_e f3;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign f3       = mem_funct3_e'(funct3_i);
   assign byte_sel = rdata_i[{off_i, 3'b000} +: 8];
   assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      ldata_o = rdata_i;
      case (f3)
         F3_B:    ldata_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ldata_o = {24'h0, byte_sel};
         F3_H:    ldata_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ldata_o = {16'h0, half_sel};
         default: ldata_o = rdata_i;
      endcase
   end

   always_comb begin
      lanes_o.be    = 4'b1111;
      lanes_o.wdata = sdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            lanes_o.be    = 4'b0001 << off_i;
            lanes_o.wdata = {4{sdata_i[7:0]}};
         end
         2'b01: begin
            lanes_o.be    = off_i[1] ? 4'b1100 : 4'b0011;
            lanes_o.wdata = {2{sdata_i[15:0]}};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/lsu_wb.sv
// RV32I load/store + writeback: single-outstanding req/gnt/rvalid access, aligned load data to the register file.
// Load accept->writeback >= 3 cycles; req_ready only in IDLE, mem_req held until mem_gnt.
module lsu_wb
   import lsu_wb_pkg::*;
#(
   parameter int DATAWIDTH   = XLEN,
   parameter int ADDRWIDTH   = 32,
   parameter int OPADDRWIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_load,
   input  logic [2:0]             req_funct3,
   input  logic [ADDRWIDTH-1:0]   req_addr,
   input  logic [DATAWIDTH-1:0]   req_wdata,
   input  logic [OPADDRWIDTH-1:0] req_rd,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [ADDRWIDTH-1:0]   mem_addr,
   output logic [3:0]             mem_be,
   output logic [DATAWIDTH-1:0]   mem_wdata,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [DATAWIDTH-1:0]   mem_rdata,
   output logic                   wb_we,
   output logic [OPADDRWIDTH-1:0] wb_rd,
   output logic [DATAWIDTH-1:0]   wb_wdata,
   output logic                   misalign,
   output logic                   busy
);
   lsu_state_e             state_q;
   logic                   ld_q;
   logic [2:0]             f3_q;
   logic [1:0]             off_q;
   logic [OPADDRWIDTH-1:0] rd_q;
   logic                   mem_req_q, mem_we_q, wb_we_q, misalign_q, busy_q;
   logic [ADDRWIDTH-1:0]   mem_addr_q;
   logic [3:0]             mem_be_q;
   logic [DATAWIDTH-1:0]   mem_wdata_q, wb_wdata_q;
   logic [OPADDRWIDTH-1:0] wb_rd_q;

   logic                   in_idle;
   logic [2:0]             align_f3;
   logic [1:0]             align_off;
   logic [DATAWIDTH-1:0]   ldata;
   store_lanes_t           lanes;

   // Store lanes come from the incoming op in IDLE; load extraction uses the latched op.
   assign in_idle   = (state_q == ST_IDLE);
   assign align_f3  = in_idle ? req_funct3 : f3_q;
   assign align_off = in_idle ? req_addr[1:0] : off_q;

   lsu_align u_align (
      .funct3_i (align_f3),
      .off_i    (align_off),
      .rdata_i  (mem_rdata),
      .sdata_i  (req_wdata),
      .ldata_o  (ldata),
      .lanes_o  (lanes)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ld_q        <= 1'b0;
         f3_q        <= '0;
         off_q       <= '0;
         rd_q        <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         wb_we_q     <= 1'b0;
         wb_rd_q     <= '0;
         wb_wdata_q  <= '0;
         misalign_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         wb_we_q    <= 1'b0;
         case (state_q)
            ST_IDLE: if (req_valid) begin
               ld_q  <= req_load;
               f3_q  <= req_funct3;
               off_q <= req_addr[1:0];
               rd_q  <= req_rd;
               if (is_misaligned(req_funct3, req_addr[1:0])) begin
                  misalign_q <= 1'b1;
               end else begin
                  state_q     <= ST_REQ;
                  busy_q      <= 1'b1;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= !req_load;
                  mem_addr_q  <= {req_addr[ADDRWIDTH-1:2], 2'b00};
                  mem_be_q    <= lanes.be;
                  mem_wdata_q <= req_load ? '0 : lanes.wdata;
               end
            end
            ST_REQ: if (mem_gnt) begin
               mem_req_q <= 1'b0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: if (mem_rvalid) begin
               if (ld_q) begin
                  state_q    <= ST_WB;
                  wb_we_q    <= (rd_q != '0);
                  wb_rd_q    <= rd_q;
                  wb_wdata_q <= ldata;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_WB: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = in_idle;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign wb_we     = wb_we_q;
   assign wb_rd     = wb_rd_q;
   assign wb_wdata  = wb_wdata_q;
   assign misalign  = misalign_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_lsu_wb.sv
// Bench for lsu_wb: directed vector table, hand-built corner sequences, randomized ops against a size/offset model.
module tb_lsu_wb;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_load = 1'b0;
   logic        req_ready;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0]  mem_be;
   logic        wb_we, misalign, busy;
   logic [4:0]  wb_rd;
   logic [31:0] wb_wdata;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   lsu_wb dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .misalign(misalign), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: derived from access size and byte offset with plain arithmetic.
   function automatic void model(input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 output logic [31:0] e_addr, output logic [3:0] e_be,
                                 output logic [31:0] e_mwd, output logic e_mis,
                                 output logic [31:0] e_wb);
      int size, off, be_i;
      logic [31:0] mask;
      size   = 1 << f3[1:0];
      off    = int'(addr % 4);
      mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      e_mis  = (addr % size) != 0;
      e_addr = addr - off;
      be_i   = ((1 << size) - 1) << off;
      e_be   = 4'(be_i);
      e_mwd  = (size == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
               (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
      e_wb   = (rdata >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && e_wb[8 * size - 1]) e_wb = e_wb | ~mask;
   endfunction

   task automatic run_op(input string tag, input logic ld, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input int gdly, input int rdly, input bit noise,
                         input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_mwd,
                         input logic e_mis, input logic [31:0] e_wb);
      int t0, nreq;
      chk({tag, ".ready"}, 32'(req_ready), 1);
      req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
      t0 = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      req_funct3 = 3'($urandom); req_rd = 5'($urandom); req_load = 1'($urandom);
      chk({tag, ".misalign"}, 32'(misalign), 32'(e_mis));
      if (e_mis) begin
         chk({tag, ".no_req"}, 32'(mem_req), 0);
         chk({tag, ".mis_busy"}, 32'(busy), 0);
         @(posedge clk); #1;
         chk({tag, ".mis_pulse"}, 32'(misalign), 0);
      end else begin
         nreq = 0;
         for (int k = 0; k <= gdly; k++) begin
            nreq += int'(mem_req);
            chk({tag, ".addr"}, mem_addr, e_addr);
            chk({tag, ".be"}, 32'(mem_be), 32'(e_be));
            chk({tag, ".we"}, 32'(mem_we), 32'(!ld));
            if (!ld) chk({tag, ".mwdata"}, mem_wdata, e_mwd);
            mem_gnt    = (k == gdly);
            mem_rvalid = noise ? 1'($urandom) : 1'b0;
            mem_rdata  = $urandom;
            @(posedge clk); #1;
         end
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         chk({tag, ".req_cycles"}, nreq, gdly + 1);
         chk({tag, ".req_drop"}, 32'(mem_req), 0);
         for (int k = 0; k < rdly; k++) begin
            @(posedge clk); #1;
         end
         mem_rvalid = 1'b1; mem_rdata = rdata;
         @(posedge clk); #1;
         mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (ld) begin
            chk({tag, ".wb_we"}, 32'(wb_we), 32'(rd != 0));
            chk({tag, ".wb_busy"}, 32'(busy), 1);
            if (rd != 0) begin
               chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
               chk({tag, ".wb_wdata"}, wb_wdata, e_wb);
               chk({tag, ".latency"}, cyc - t0, 3 + gdly + rdly);
            end
            @(posedge clk); #1;
            chk({tag, ".wb_pulse"}, 32'(wb_we), 0);
         end else begin
            chk({tag, ".st_no_wb"}, 32'(wb_we), 0);
         end
         chk({tag, ".idle"}, 32'(busy), 0);
      end
   endtask

   typedef struct {
      logic        ld;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rdata;
      logic [4:0]  rd;
      int          gd, rdly;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_mwd;
      logic        e_mis;
      logic [31:0] e_wb;
   } vec_t;

   vec_t tv[$];

   initial begin
      logic [31:0] e_addr, e_mwd, e_wb, addr, wdata, rdata;
      logic [3:0]  e_be;
      logic        e_mis, ld;
      logic [2:0]  f3;
      logic [2:0]  ld_f3s[5];

      //         ld    f3      addr        wdata         rdata         rd  gd rv e_addr      be       e_mwd         mis   e_wb
      tv.push_back('{1'b1, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 5,  0, 0, 32'h104, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF});
      tv.push_back('{1'b1, 3'b000, 32'h103, 32'h0,        32'h80112233, 7,  0, 0, 32'h100, 4'b1000, 32'h0,        1'b0, 32'hFFFFFF80});
      tv.push_back('{1'b1, 3'b100, 32'h103, 32'h0,        32'h80112233, 7,  0, 0, 32'h100, 4'b1000, 32'h0,        1'b0, 32'h00000080});
      tv.push_back('{1'b1, 3'b101, 32'h102, 32'h0,        32'h80112233, 8,  0, 0, 32'h100, 4'b1100, 32'h0,        1'b0, 32'h00008011});
      tv.push_back('{1'b0, 3'b000, 32'h201, 32'h000000AB, 32'h0,        0,  0, 0, 32'h200, 4'b0010, 32'hABABABAB, 1'b0, 32'h0});
      tv.push_back('{1'b0, 3'b001, 32'h202, 32'h1234CDEF, 32'h0,        0,  0, 0, 32'h200, 4'b1100, 32'hCDEFCDEF, 1'b0, 32'h0});
      tv.push_back('{1'b0, 3'b010, 32'h20C, 32'h11223344, 32'h0,        0,  2, 1, 32'h20C, 4'b1111, 32'h11223344, 1'b0, 32'h0});
      tv.push_back('{1'b1, 3'b010, 32'h300, 32'h0,        32'h12345678, 0,  3, 1, 32'h300, 4'b1111, 32'h0,        1'b0, 32'h0});
      tv.push_back('{1'b1, 3'b010, 32'h106, 32'h0,        32'h0,        4,  0, 0, 32'h0,   4'b0000, 32'h0,        1'b1, 32'h0});
      tv.push_back('{1'b1, 3'b001, 32'h101, 32'h0,        32'h0,        4,  0, 0, 32'h0,   4'b0000, 32'h0,        1'b1, 32'h0});
      tv.push_back('{1'b0, 3'b010, 32'h202, 32'h0,        32'h0,        0,  0, 0, 32'h0,   4'b0000, 32'h0,        1'b1, 32'h0});
      tv.push_back('{1'b0, 3'b001, 32'h203, 32'h0,        32'h0,        0,  0, 0, 32'h0,   4'b0000, 32'h0,        1'b1, 32'h0});
      tv.push_back('{1'b1, 3'b001, 32'h100, 32'h0,        32'h0000F00D, 9,  0, 0, 32'h100, 4'b0011, 32'h0,        1'b0, 32'hFFFFF00D});
      tv.push_back('{1'b1, 3'b000, 32'h100, 32'h0,        32'h0000007F, 10, 1, 0, 32'h100, 4'b0001, 32'h0,        1'b0, 32'h0000007F});
      tv.push_back('{1'b1, 3'b000, 32'h102, 32'h0,        32'h00AB0000, 11, 1, 2, 32'h100, 4'b0100, 32'h0,        1'b0, 32'hFFFFFFAB});

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst.ready", 32'(req_ready), 1);
      chk("rst.mem_req", 32'(mem_req), 0);
      chk("rst.mem_we", 32'(mem_we), 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.mem_be", 32'(mem_be), 0);
      chk("rst.mem_wdata", mem_wdata, 0);
      chk("rst.wb", {26'h0, wb_we, wb_rd}, 0);
      chk("rst.wb_wdata", wb_wdata, 0);
      chk("rst.misalign", 32'(misalign), 0);
      chk("rst.busy", 32'(busy), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (tv[i])
         run_op($sformatf("tv%0d", i), tv[i].ld, tv[i].f3, tv[i].addr, tv[i].wdata, tv[i].rdata,
                tv[i].rd, tv[i].gd, tv[i].rdly, 1'b0,
                tv[i].e_addr, tv[i].e_be, tv[i].e_mwd, tv[i].e_mis, tv[i].e_wb);

      // Misaligned access immediately followed by a valid one
      req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h106; req_rd = 5'd3;
      @(posedge clk); #1;
      chk("b2b.misalign", 32'(misalign), 1);
      chk("b2b.ready", 32'(req_ready), 1);
      req_addr = 32'h108;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b.mem_req", 32'(mem_req), 1);
      chk("b2b.mem_addr", mem_addr, 32'h108);
      chk("b2b.mis_clear", 32'(misalign), 0);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      chk("b2b.wb_we", 32'(wb_we), 1);
      chk("b2b.wb_wdata", wb_wdata, 32'hCAFEF00D);
      @(posedge clk); #1;

      // Reset while waiting for the response; the late response must be dropped
      req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h110; req_rd = 5'd9;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      chk("rstw.busy_before", 32'(busy), 1);
      rst = 1'b1;
      #1;
      chk("rstw.ready", 32'(req_ready), 1);
      chk("rstw.mem", {30'h0, mem_req, mem_we}, 0);
      chk("rstw.mem_addr", mem_addr, 0);
      chk("rstw.mem_be", 32'(mem_be), 0);
      chk("rstw.wb", {26'h0, wb_we, wb_rd}, 0);
      chk("rstw.wb_wdata", wb_wdata, 0);
      chk("rstw.busy", {30'h0, busy, misalign}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      chk("rstw.no_wb", 32'(wb_we), 0);
      chk("rstw.idle", 32'(busy), 0);
      @(posedge clk); #1;
      chk("rstw.no_wb2", 32'(wb_we), 0);
      chk("rstw.ready2", 32'(req_ready), 1);

      // Randomized ops with stale/spurious responses mixed in
      ld_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int n = 0; n < 80; n++) begin
         ld    = 1'($urandom);
         f3    = ld ? ld_f3s[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         addr  = 32'h1000 + 32'($urandom_range(0, 63));
         wdata = $urandom;
         rdata = $urandom;
         model(f3, addr, wdata, rdata, e_addr, e_be, e_mwd, e_mis, e_wb);
         mem_rvalid = 1'b1; mem_rdata = $urandom;
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         chk("stale.busy", 32'(busy), 0);
         chk("stale.wb_we", 32'(wb_we), 0);
         run_op($sformatf("rnd%0d", n), ld, f3, addr, wdata, rdata, 5'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2), 1'b1,
                e_addr, e_be, e_mwd, e_mis, e_wb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lsu_wb.md
# lsu_wb

Load/store and writeback stage of the RV32I core. Takes one memory instruction at a time from execute, runs a single-outstanding request/grant/response transaction on the data-memory port, and aligns and sign-extends load data. It drives the register file write port (we/rd/rd_wdata). Little-endian throughout, matching the register file and memory.

## Interface
- DATAWIDTH, 32, data and register width
- ADDRWIDTH, 32, byte address width
- OPADDRWIDTH, 5, register index width
- clk  in  1  clock; all flops rise-edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  execute presents a memory op
- req_ready  out  1  stage can accept; high only in IDLE
- req_load  in  1  1 = load, 0 = store
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  ADDRWIDTH  effective byte address
- req_wdata  in  DATAWIDTH  store data (rs2 value)
- req_rd  in  OPADDRWIDTH  load destination
- mem_req  out  1  memory request, held until granted
- mem_we  out  1  1 = store
- mem_addr  out  ADDRWIDTH  word-aligned address {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  DATAWIDTH  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response (load data or store ack)
- mem_rdata  in  DATAWIDTH  load word
- wb_we, wb_rd, wb_wdata  out  1/OPADDRWIDTH/DATAWIDTH  to register file we/rd/rd_wdata
- misalign  out  1  one-cycle pulse on a misaligned access
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT, WB.
- IDLE:
  - req_valid && req_ready latches the op.
  - If the op is misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0), pulse misalign next cycle, issue no memory access, and stay in IDLE.
  - Otherwise go to REQ.
- REQ: mem_req=1 with stable mem_addr/mem_we/mem_be/mem_wdata. On mem_gnt go to WAIT. Ignore mem_rvalid in REQ.
- WAIT: on mem_rvalid:
  - load: capture the aligned result and go to WB;
  - store: go to IDLE.
- WB: wb_we=1 for exactly one cycle, then IDLE. Force wb_we=0 when rd==0; the memory access still occurs.
- Load extract, off=addr[1:0]:
  - LB/LBU: byte mem_rdata[8*off+7:8*off], sign- or zero-extended.
  - LH/LHU: half selected by off[1], extended.
  - LW: full word.
- Store lanes:
  - SB: wdata={4{b}}, be=4'b0001<<off.
  - SH: wdata={2{h}}, be=off[1]?4'b1100:4'b0011.
  - SW: be=4'b1111.
- Ignore mem_rvalid in IDLE (stale response after reset).

## Timing
- Reset: state=IDLE. req_ready=1. All other outputs 0 (mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_we, wb_rd, wb_wdata, misalign, busy).
- All mem_* and wb_* outputs are registered. req_ready is decoded from state.
- Accept at edge T; mem_req high from T+1. Grant in the same cycle as mem_req is allowed.
- mem_rvalid comes no earlier than the cycle after mem_gnt.
- Load: mem_rvalid in cycle N gives wb_we in cycle N+1. Minimum load latency, accept to writeback: 3 cycles. Store: next accept possible the cycle after rvalid.
- Misaligned: misalign high at T+1, req_ready stays 1, back-to-back accepts allowed.
- rst asserted mid-transaction: immediate return to IDLE and outputs to reset values. The outstanding response is discarded.

## Structure
- The funct3 load/store encodings and the state encoding go in the shared RV32I.h definitions.
- One combinational sub-module, lsu_align: load extract/extend plus store lane replication and byte enables. It is reused by the instruction-fetch side later.

## Test plan
- LW addr=0x104, mem_rdata=0xDEADBEEF, gnt immediate, rvalid next cycle -> mem_addr=0x104, be=4'hF; wb_we=1, rd=5, wdata=0xDEADBEEF exactly 3 cycles after accept.
- LB addr=0x103, rdata=0x80112233 -> wdata=0xFFFFFF80; LBU -> 0x00000080; LHU addr=0x102 -> 0x00008011.
- SB addr=0x201, wdata=0x000000AB -> mem_wdata=0xABABABAB, be=4'b0010, mem_we=1, no wb_we; SH addr=0x202 -> be=4'b1100.
- gnt delayed 3 cycles, then LW to rd=0 -> mem_req held stable 4 cycles; rvalid arrives, wb_we stays 0; busy returns 0.
- LW addr=0x106 -> misalign pulse at T+1, mem_req never asserted, next request accepted at T+1.
- rst asserted in WAIT, then mem_rvalid arrives after release -> outputs at reset values, no wb_we, state IDLE.
